mm_result_collector: RTL

//   Receive end of the Montgomery datapath word stream: captures 32-bit result words leaving
//   the pipeline tail (after the fixed-delay alignment stages) and packs them into a full

---
 rtl/mm_pkg.sv | 17 +
 rtl/mm_result_collector_if.sv | 25 ++
 rtl/mm_collect_wdog.sv | 31 +++
 rtl/mm_result_collector.sv | 114 +++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared constants and state encoding for the Montgomery result collector.
package mm_pkg;

    localparam int WORD_W      = 32;
    localparam int NWORDS      = 32;
    localparam int CNT_W       = $clog2(NWORDS + 1);
    localparam int TIMEOUT_CYC = 64;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } collect_state_t;

endpackage

// File: rtl/mm_result_collector_if.sv
// Word-in / result-out bundle between the datapath tail, the collector and the readout logic.
interface mm_result_collector_if;
    import mm_pkg::*;

    logic                     start_i;
    logic                     word_vld_i;
    logic [WORD_W-1:0]        word_i;
    logic                     res_rdy_i;
    logic                     busy_o;
    logic                     done_o;
    logic [NWORDS*WORD_W-1:0] res_o;
    logic                     overflow_o;
    logic                     timeout_o;

    modport master (
        output start_i, word_vld_i, word_i, res_rdy_i,
        input  busy_o, done_o, res_o, overflow_o, timeout_o
    );

    modport slave (
        input  start_i, word_vld_i, word_i, res_rdy_i,
        output busy_o, done_o, res_o, overflow_o, timeout_o
    );

endinterface

// File: rtl/mm_collect_wdog.sv
// Idle-cycle watchdog for the collector; only built when MM_COLLECT_TIMEOUT_EN is defined.
`ifdef MM_COLLECT_TIMEOUT_EN
module mm_collect_wdog
    import mm_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic active,
    input  logic kick,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] idle_cnt;

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle, so the owner leaves on that edge.
    assign expire = active & ~kick & (idle_cnt == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt <= '0;
        end else if (!active || kick || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + W'(1);
        end
    end

endmodule
`endif

// File: rtl/mm_result_collector.sv
// Packs NWORDS datapath words into one result and hands it off with valid/ready.
// Optional idle watchdog enabled by defining MM_COLLECT_TIMEOUT_EN.
module mm_result_collector
    import mm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    mm_result_collector_if.slave bus
);

    collect_state_t           state;
    logic [CNT_W-1:0]         count;
    logic [NWORDS*WORD_W-1:0] res;
    logic                     busy;
    logic                     done;
    logic                     overflow;
    logic                     timeout;

    logic              start;
    logic              vld;
    logic [WORD_W-1:0] word;
    logic              handshake;
    logic              begin_collect;
    logic              wdog_expire;

    assign start = bus.start_i;
    assign vld   = bus.word_vld_i;
    assign word  = bus.word_i;

    assign handshake     = (state == ST_FULL) & bus.res_rdy_i;
    // A start during FULL only counts when it coincides with the handoff.
    assign begin_collect = start & ((state != ST_FULL) | handshake);

`ifdef MM_COLLECT_TIMEOUT_EN
    mm_collect_wdog u_wdog (
        .clk    (clk),
        .rstn   (rstn),
        .active (state == ST_COLLECT),
        .kick   (start | vld),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            count    <= '0;
            res      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= wdog_expire;
            if (begin_collect) begin
                state    <= ST_COLLECT;
                busy     <= 1'b1;
                done     <= 1'b0;
                overflow <= 1'b0;
                if (vld) begin
                    res[WORD_W-1:0] <= word;
                    count           <= CNT_W'(1);
                end else begin
                    count <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (vld) overflow <= 1'b1;
                    end
                    ST_COLLECT: begin
                        if (wdog_expire) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            count <= '0;
                        end else if (vld) begin
                            res[int'(count)*WORD_W +: WORD_W] <= word;
                            if (count == LAST_IDX) begin
                                state <= ST_FULL;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                count <= '0;
                            end else begin
                                count <= count + CNT_W'(1);
                            end
                        end
                    end
                    ST_FULL: begin
                        if (vld) overflow <= 1'b1;
                        if (handshake) begin
                            state <= ST_IDLE;
                            done  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o     = busy;
    assign bus.done_o     = done;
    assign bus.res_o      = res;
    assign bus.overflow_o = overflow;
    assign bus.timeout_o  = timeout;

endmodule
